// File: rtl/div_pkg.sv
// Shared types and width constant for the sequential restoring divider.
package div_pkg;

  localparam int unsigned DIV_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

endpackage

// File: rtl/sub_nb.sv
// N-bit ripple-borrow subtractor (diff = a - b) built from full-subtractor cells.
module sub_nb #(
  parameter int unsigned N = 5
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff,
  output logic         b_out
);

  logic [N:0] bw;

  assign bw[0] = 1'b0;

  for (genvar i = 0; i < N; i++) begin : g_cell
    // Borrow out when a < b + borrow_in at this bit.
    assign diff[i]  = a[i] ^ b[i] ^ bw[i];
    assign bw[i+1]  = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & bw[i]);
  end

  assign b_out = bw[N];

endmodule

// File: rtl/div_4b_seq.sv
// Sequential restoring divider, one quotient bit per clock, valid/ready in and out.
// Optional early divide-by-zero exit when DIV_BY_ZERO_CHK_EN is defined.
module div_4b_seq
  import div_pkg::*;
#(
  parameter int unsigned W = DIV_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         div_by_zero
);

  localparam int unsigned RW = W + 1;
  localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [RW-1:0] r;
  logic [W-1:0]  q;
  logic [W-1:0]  d;

  logic [RW-1:0] r_sh;
  logic [RW-1:0] t;
  logic [RW-1:0] r_nxt;
  logic [W-1:0]  q_nxt;
  logic          borrow;

  // Shift the next dividend bit into the partial remainder, then trial-subtract.
  assign r_sh = RW'({r, q[W-1]});

  sub_nb #(.N(RW)) u_sub (
    .a     (r_sh),
    .b     ({1'b0, d}),
    .diff  (t),
    .b_out (borrow)
  );

  assign r_nxt = borrow ? r_sh : t;
  assign q_nxt = W'({q, ~borrow});

`ifdef DIV_BY_ZERO_CHK_EN
  logic dz;
  assign div_by_zero = dz;
`else
  assign div_by_zero = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      cnt       <= '0;
      r         <= '0;
      q         <= '0;
      d         <= '0;
`ifdef DIV_BY_ZERO_CHK_EN
      dz        <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            d        <= divisor;
            q        <= dividend;
            r        <= '0;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= BUSY;
`ifdef DIV_BY_ZERO_CHK_EN
            if (divisor == '0) begin
              state     <= DONE;
              quotient  <= '1;
              remainder <= dividend;
              dz        <= 1'b1;
            end
`endif
          end
        end
        BUSY: begin
          r   <= r_nxt;
          q   <= q_nxt;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(W - 1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
            quotient  <= q_nxt;
            remainder <= r_nxt[W-1:0];
          end
        end
        DONE: begin
          // Early-exit path enters DONE with out_valid low; raise it one cycle later.
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
`ifdef DIV_BY_ZERO_CHK_EN
            dz        <= 1'b0;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_4b_seq.sv
// Self-checking bench for div_4b_seq: vector table, corner sequences, random and exhaustive sweeps.
module tb_div_4b_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] dividend;
  logic [3:0] divisor;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;

  int tests = 0;
  int fails = 0;

`ifdef DIV_BY_ZERO_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  div_4b_seq #(.W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] eq;
    logic [3:0] er;
  } vec_t;

  task automatic chk(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  // Reference: plain integer division; divisor 0 gives all-ones quotient and dividend remainder.
  task automatic ref_model(input logic [3:0] a, input logic [3:0] b,
                           output int eq, output int er, output int ez, output int elat);
    if (b == 0) begin
      eq = 15;
      er = int'(a);
      ez = CHK ? 1 : 0;
      elat = CHK ? 1 : 4;
    end else begin
      eq = int'(a) / int'(b);
      er = int'(a) % int'(b);
      ez = 0;
      elat = 4;
    end
  endtask

  // Issue one operation, measure latency, optionally stall the result and poke in_valid meanwhile.
  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input int stall, input string tag);
    int eq, er, ez, elat, lat, w;
    ref_model(a, b, eq, er, ez, elat);
    w = 0;
    while (!in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk({tag, "_in_ready_wait"}, int'(in_ready), 1);
    if (!in_ready) return;
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, "_busy_not_ready"}, int'(in_ready), 0);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, lat, elat);
    chk({tag, "_quotient"}, int'(quotient), eq);
    chk({tag, "_remainder"}, int'(remainder), er);
    chk({tag, "_div_by_zero"}, int'(div_by_zero), ez);
    for (int s = 0; s < stall; s++) begin
      if (s == 0) begin
        in_valid = 1'b1;
        dividend = a ^ 4'hf;
        divisor  = 4'd1;
      end
      @(negedge clk);
      chk({tag, "_hold_valid"}, int'(out_valid), 1);
      chk({tag, "_hold_q"}, int'(quotient), eq);
      chk({tag, "_hold_r"}, int'(remainder), er);
      chk({tag, "_hold_not_ready"}, int'(in_ready), 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_post_valid"}, int'(out_valid), 0);
    chk({tag, "_post_ready"}, int'(in_ready), 1);
    chk({tag, "_post_dbz"}, int'(div_by_zero), 0);
  endtask

  vec_t vecs [10];

  initial begin
    vecs[0] = '{a: 4'd13, b: 4'd3,  eq: 4'd4,  er: 4'd1};
    vecs[1] = '{a: 4'd15, b: 4'd1,  eq: 4'd15, er: 4'd0};
    vecs[2] = '{a: 4'd5,  b: 4'd7,  eq: 4'd0,  er: 4'd5};
    vecs[3] = '{a: 4'd12, b: 4'd5,  eq: 4'd2,  er: 4'd2};
    vecs[4] = '{a: 4'd9,  b: 4'd0,  eq: 4'd15, er: 4'd9};
    vecs[5] = '{a: 4'd14, b: 4'd4,  eq: 4'd3,  er: 4'd2};
    vecs[6] = '{a: 4'd0,  b: 4'd5,  eq: 4'd0,  er: 4'd0};
    vecs[7] = '{a: 4'd15, b: 4'd15, eq: 4'd1,  er: 4'd0};
    vecs[8] = '{a: 4'd15, b: 4'd2,  eq: 4'd7,  er: 4'd1};
    vecs[9] = '{a: 4'd1,  b: 4'd0,  eq: 4'd15, er: 4'd1};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    #1;
    chk("reset_in_ready", int'(in_ready), 1);
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_quotient", int'(quotient), 0);
    chk("reset_remainder", int'(remainder), 0);
    chk("reset_dbz", int'(div_by_zero), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Table vectors: hand-computed expectations, plus a direct cross-check of the table itself.
    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].a, vecs[i].b, 0, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d_tbl_q", i), int'(quotient), int'(vecs[i].eq));
      chk($sformatf("vec%0d_tbl_r", i), int'(remainder), int'(vecs[i].er));
    end

    // Backpressure with an ignored in_valid while the result is held.
    run_op(4'd12, 4'd5, 3, "bp");

    // Asynchronous reset two cycles into BUSY aborts the operation.
    in_valid = 1'b1;
    dividend = 4'd13;
    divisor  = 4'd3;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", int'(out_valid), 0);
    chk("arst_quotient", int'(quotient), 0);
    chk("arst_remainder", int'(remainder), 0);
    chk("arst_in_ready", int'(in_ready), 1);
    chk("arst_dbz", int'(div_by_zero), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("arst_no_result", int'(out_valid), 0);
    run_op(4'd14, 4'd4, 0, "after_rst");

    // Random operands and stalls against the reference model.
    for (int i = 0; i < 40; i++) begin
      run_op(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
             int'($urandom_range(0, 2)), $sformatf("rnd%0d", i));
    end

    // Exhaustive sweep of every operand pair.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        run_op(4'(a), 4'(b), 0, $sformatf("sw_%0d_%0d", a, b));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
